// File: rtl/count_display_driver.sv
// 8-bit count to 3-digit BCD (sequential double-dabble) driving a multiplexed
// 4-digit common-anode 7-segment display with optional leading-zero blanking.
module count_display_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  value,
  output logic [11:0] bcd,
  output logic        bcd_valid,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] REFRESH_TERM = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg;
  logic [19:0]      shift_reg;
  logic [2:0]       iter_reg;
  logic [11:0]      bcd_reg;
  logic             bcd_valid_reg;
  logic [19:0]      shift_adj;

  logic [CNT_W-1:0] refresh_cnt_reg;
  logic [1:0]       scan_idx_reg;
  logic [3:0]       an_reg;
  logic [6:0]       seg_reg;
  logic [3:0]       an_next;
  logic [6:0]       seg_next;

  // Add-3 correction on each BCD nibble before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib = shift_reg[8 + 4*gi +: 4];
      assign shift_adj[8 + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate
  assign shift_adj[7:0] = shift_reg[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      iter_reg      <= '0;
      bcd_reg       <= '0;
      bcd_valid_reg <= 1'b0;
    end else begin
      bcd_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          shift_reg <= {12'b0, value};
          iter_reg  <= '0;
          state_reg <= SHIFT;
        end
        SHIFT: begin
          shift_reg <= shift_adj << 1;
          iter_reg  <= iter_reg + 3'd1;
          if (iter_reg == 3'd7) state_reg <= DONE;
        end
        DONE: begin
          bcd_reg       <= shift_reg[19:8];
          bcd_valid_reg <= 1'b1;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // Display works only from the registered result, never the in-flight register.
  always_comb begin
    an_next  = 4'b1111;
    seg_next = 7'b1111111;
    case (scan_idx_reg)
      2'd0: begin
        an_next  = 4'b1110;
        seg_next = seg_of(bcd_reg[3:0]);
      end
      2'd1: begin
        if (!(LZ_BLANK && bcd_reg[11:8] == 4'd0 && bcd_reg[7:4] == 4'd0)) begin
          an_next  = 4'b1101;
          seg_next = seg_of(bcd_reg[7:4]);
        end
      end
      2'd2: begin
        if (!(LZ_BLANK && bcd_reg[11:8] == 4'd0)) begin
          an_next  = 4'b1011;
          seg_next = seg_of(bcd_reg[11:8]);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt_reg <= '0;
      scan_idx_reg    <= '0;
      an_reg          <= 4'b1111;
      seg_reg         <= 7'b1111111;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
      if (refresh_cnt_reg == REFRESH_TERM) begin
        refresh_cnt_reg <= '0;
        scan_idx_reg    <= scan_idx_reg + 2'd1;
      end else begin
        refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
      end
    end
  end

  assign bcd       = bcd_reg;
  assign bcd_valid = bcd_valid_reg;
  assign seg       = seg_reg;
  assign an        = an_reg;
  assign dp        = 1'b1;

endmodule
